// File: rtl/tc_gen.sv
// Timer/counter with NUM_CH output-compare channels behind a byte-wide register port.
// 16-bit registers are accessed atomically through a shared TEMP byte.
module tc_gen #(
    parameter int         WIDTH  = 8,
    parameter int         NUM_CH = 2,
    parameter logic [7:0] BASE   = 8'h40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic              read,
    input  logic [7:0]        addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              interrupt_request,
    input  logic              interrupt_executed,
    output logic [NUM_CH-1:0] oc_out
);

    localparam int               NF   = NUM_CH + 1;
    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [1:0]       MODE_CTC = 2'b01;
    localparam logic [1:0]       MODE_PWM = 2'b10;
    localparam logic [7:0]       OFF_CTRL   = 8'd0,
                                 OFF_TCNT_L = 8'd1,
                                 OFF_TCNT_H = 8'd2,
                                 OFF_TIMSK  = 8'd11,
                                 OFF_TIFR   = 8'd12;

    logic [4:0]        ctrl;
    logic [WIDTH-1:0]  tcnt;
    logic [WIDTH-1:0]  ocr     [NUM_CH];
    logic [WIDTH-1:0]  ocr_buf [NUM_CH];
    logic [15:0]       ocr_buf16 [NUM_CH];
    logic [NF-1:0]     timsk;
    logic [NF-1:0]     tifr;
    logic [7:0]        temp;
    logic [9:0]        prescaler;

    logic [7:0]        offset;
    logic              rd;
    logic              is_pwm;
    logic              is_ctc;
    logic              wr_ctrl, wr_tcnt_l, wr_tcnt_h, wr_timsk, wr_tifr, rd_tcnt_l;
    logic [NUM_CH-1:0] wr_ocr_l, wr_ocr_h, rd_ocr_l;
    logic [WIDTH-1:0]  wr_value;
    logic [15:0]       tcnt16;
    logic [7:0]        temp_rd;
    logic [7:0]        rd_value;
    logic              tick, count, wrap, ctc_clear;
    logic [NUM_CH-1:0] match, pwm_clear;
    logic [NF-1:0]     tifr_set, tifr_clr;

    assign offset    = addr - BASE;
    assign rd        = read & ~write;
    assign is_pwm    = (ctrl[1:0] == MODE_PWM);
    assign is_ctc    = (ctrl[1:0] == MODE_CTC);
    assign wr_ctrl   = write && (offset == OFF_CTRL);
    assign wr_tcnt_l = write && (offset == OFF_TCNT_L);
    assign wr_tcnt_h = write && (offset == OFF_TCNT_H);
    assign wr_timsk  = write && (offset == OFF_TIMSK);
    assign wr_tifr   = write && (offset == OFF_TIFR);
    assign rd_tcnt_l = rd && (offset == OFF_TCNT_L);
    assign tcnt16    = 16'(tcnt);
    assign wr_value  = (WIDTH == 16) ? WIDTH'({temp, wdata}) : WIDTH'(wdata);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ocr_l[i]  = write && (offset == 8'(3 + 2 * i));
            wr_ocr_h[i]  = write && (offset == 8'(4 + 2 * i));
            rd_ocr_l[i]  = rd && (offset == 8'(3 + 2 * i));
            ocr_buf16[i] = 16'(ocr_buf[i]);
        end
    end

    // High byte captured into TEMP by a low-byte read, so a later high read is coherent
    always_comb begin
        temp_rd = tcnt16[15:8];
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ocr_l[i]) temp_rd = ocr_buf16[i][15:8];
        end
    end

    always_comb begin
        case (offset)
            OFF_CTRL:   rd_value = {3'b000, ctrl};
            OFF_TCNT_L: rd_value = tcnt16[7:0];
            OFF_TCNT_H: rd_value = (WIDTH == 16) ? temp : 8'h00;
            OFF_TIMSK:  rd_value = 8'(timsk);
            OFF_TIFR:   rd_value = 8'(tifr);
            default:    rd_value = 8'h00;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (offset == 8'(3 + 2 * i)) rd_value = ocr_buf16[i][7:0];
            if (offset == 8'(4 + 2 * i)) rd_value = (WIDTH == 16) ? temp : 8'h00;
        end
    end

    always_comb begin
        case (ctrl[4:2])
            3'b001:  tick = 1'b1;
            3'b010:  tick = &prescaler[2:0];
            3'b011:  tick = &prescaler[5:0];
            3'b100:  tick = &prescaler[7:0];
            3'b101:  tick = &prescaler;
            default: tick = 1'b0;
        endcase
    end

    // A software TCNT write owns the cycle: no increment, no wrap, no compare events
    assign count     = tick & ~wr_tcnt_l;
    assign wrap      = count && (tcnt == MAX);
    assign ctc_clear = count && is_ctc && (tcnt == ocr[0]);

    // PWM compares against the upcoming count so the output stays high for exactly OCR ticks
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            match[i]     = count && (tcnt == ocr[i]);
            pwm_clear[i] = count && (ocr[i] != MAX) && ((tcnt + ONE) == ocr[i]);
        end
    end

    assign tifr_set = {match, wrap};
    assign tifr_clr = (wr_tifr ? wdata[NF-1:0] : '0) |
                      (interrupt_executed ? (tifr & timsk) : '0);
    assign interrupt_request = |(tifr & timsk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt      <= '0;
            prescaler <= '0;
        end else begin
            if (wr_ctrl && (wdata[4:2] != ctrl[4:2])) prescaler <= '0;
            else                                      prescaler <= prescaler + 10'd1;
            if (wr_tcnt_l)               tcnt <= wr_value;
            else if (wrap || ctc_clear)  tcnt <= '0;
            else if (count)              tcnt <= tcnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl  <= '0;
            timsk <= '0;
            tifr  <= '0;
            temp  <= '0;
            rdata <= '0;
        end else begin
            if (wr_ctrl)  ctrl  <= wdata[4:0];
            if (wr_timsk) timsk <= wdata[NF-1:0];
            tifr <= (tifr & ~tifr_clr) | tifr_set;
            if ((WIDTH == 16) && (wr_tcnt_h || (|wr_ocr_h)))      temp <= wdata;
            else if ((WIDTH == 16) && (rd_tcnt_l || (|rd_ocr_l))) temp <= temp_rd;
            if (rd) rdata <= rd_value;
        end
    end

    // In fast PWM, OCR writes land in the buffer and take effect at the next wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ocr[i]     <= '0;
                ocr_buf[i] <= '0;
            end
            oc_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ocr_l[i]) begin
                    ocr_buf[i] <= wr_value;
                    if (!is_pwm) ocr[i] <= wr_value;
                end
                if (is_pwm) begin
                    if (wrap) begin
                        ocr[i]    <= ocr_buf[i];
                        oc_out[i] <= (ocr_buf[i] != '0);
                    end else if (pwm_clear[i]) begin
                        oc_out[i] <= 1'b0;
                    end
                end else if (match[i]) begin
                    oc_out[i] <= ~oc_out[i];
                end
            end
        end
    end

endmodule

// File: doc/tc_gen.md
TC_GEN -- requirements
Module: tc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/compare width; legal values 8 or 16.
REQ-002 SHALL have parameter NUM_CH, default 2, number of compare channels; legal range 1..4.
REQ-003 SHALL have parameter BASE, default 8'h40, base register address.
REQ-004 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port write  in  1  register write strobe, one cycle.
REQ-007 SHALL have port read  in  1  register read strobe, one cycle; write has priority if both are high.
REQ-008 SHALL have port addr  in  8  register address.
REQ-009 SHALL have port wdata  in  8  write data.
REQ-010 SHALL have port rdata  out  8  registered read data.
REQ-011 SHALL have port interrupt_request  out  1  level interrupt to the core.
REQ-012 SHALL have port interrupt_executed  in  1  one-cycle acknowledge from the core.
REQ-013 SHALL have port oc_out  out  NUM_CH  compare/PWM waveform outputs.

Function
REQ-014 SHALL decode the register map: BASE+0 CTRL; BASE+1/+2 TCNT low/high; BASE+3+2i/+4+2i OCRi low/high; BASE+11 TIMSK; BASE+12 TIFR; other addresses: writes ignored, reads return 0.
REQ-015 SHALL define CTRL[1:0] mode (00 normal, 01 CTC, 10 fast PWM, 11 treated as normal) and CTRL[4:2] clock select (000 stopped, 001 /1, 010 /8, 011 /64, 100 /256, 101 /1024, 110-111 stopped).
REQ-016 SHALL return rdata one cycle after the read strobe and hold it until the next read.
REQ-017 SHALL write 16-bit registers atomically: a high-byte write loads a shared TEMP; a low-byte write commits {TEMP, wdata}.
REQ-018 SHALL read 16-bit registers atomically: a low-byte read also latches the high byte into TEMP; a high-byte read returns TEMP.
REQ-019 SHALL, when WIDTH=8, ignore high-byte writes, return 0 on high-byte reads, and make low-byte accesses direct.
REQ-020 SHALL generate a one-cycle tick from a free-running 10-bit prescaler in clk; no derived clocks.
REQ-021 SHALL clear the prescaler whenever CTRL[4:2] is written with a changed value; the first tick then follows exactly N clks later.
REQ-022 SHALL advance TCNT only on a tick; a TCNT write in the same cycle as a tick takes the written value, suppresses that increment, and suppresses compare matches for that cycle.
REQ-023 SHALL, in normal mode, count 0..MAX (2^WIDTH-1) and wrap MAX->0, setting TIFR[0] (TOV) on the wrap tick.
REQ-024 SHALL, in CTC mode, load TCNT=0 on the tick where TCNT==OCR0; if TCNT>OCR0, count to MAX, wrap, and set TOV.
REQ-025 SHALL, in fast PWM mode, wrap at MAX, set TOV on wrap, load each OCRi from its write buffer on the wrap tick, and set oc_out[i]=1 at wrap.
REQ-026 SHALL, in fast PWM mode, clear oc_out[i] on match, except that OCRi==MAX gives constant 1.
REQ-027 SHALL, in normal and CTC modes, write OCRi immediately and toggle oc_out[i] on each match.
REQ-028 SHALL set TIFR[i+1] (OCFi) on any tick where pre-increment TCNT==OCRi, in every mode.
REQ-029 SHALL clear TIFR bits by writing 1 to them; a set event in the same cycle wins.
REQ-030 SHALL drive interrupt_request = |(TIFR & TIMSK), combinationally from registers.
REQ-031 SHALL, on interrupt_executed, clear all TIFR bits that are both set and enabled; a simultaneous set event wins.

Reset
REQ-032 SHALL, on rst_n low, immediately clear CTRL, TCNT, all OCRi and their buffers, TIMSK, TIFR, TEMP, the prescaler, rdata and oc_out, and deassert interrupt_request.
REQ-033 SHALL hold that state while rst_n is low, including mid-count, and resume counting only after a new CTRL write.

Verification
REQ-034 SHALL verify: WIDTH=8, CTRL=001_00 (normal, /1), TIMSK=01 -> TOV set and interrupt_request=1 exactly 256 clks after start; interrupt_executed -> TIFR=0.
REQ-035 SHALL verify: CTC, OCR0=9, /8 -> TCNT sequence 0..9,0 with OCF0 set every 80 clks and oc_out[0] toggling each match.
REQ-036 SHALL verify: WIDTH=16, write high 8'h12 then low 8'h34 to OCR1 -> reads low then high return 8'h34, 8'h12; a high-byte write alone leaves OCR1 unchanged.
REQ-037 SHALL verify: fast PWM, OCR0=64, /1, then OCR0 written as 128 mid-period -> oc_out[0] high 64 clks for the current period and 128 clks from the next wrap.
REQ-038 SHALL verify: a TIFR write-1 clear in the same cycle as an OCF0 match -> OCF0 remains 1; a TCNT write coinciding with a tick -> written value held, no match.
REQ-039 SHALL verify: rst_n asserted mid-count with TCNT=8'h5A -> all registers 0, rdata=0, oc_out=0 within the same cycle; no counting after release until CTRL is written.
